// File: rtl/fold_scheduler_rr_if.sv
// Request/grant bundle between the partition request generator,
// the fold scheduler and the folded link muxes.
interface fold_scheduler_rr_if #(
    parameter int WIDTH = 8,
    parameter int FOLDS = 2
);
    localparam int SW = $clog2(WIDTH);

    logic                      i_req_valid;
    logic                      o_req_ready;
    logic [WIDTH-1:0]          i_request;
    logic                      i_mode;
    logic                      i_stall;
    logic [FOLDS-1:0][SW-1:0]  o_mux_sel;
    logic [FOLDS-1:0]          o_mux_valid;
    logic                      o_busy;
    logic                      o_adone;
    logic                      o_done;

    // Request source side: drives the vector, sees grants.
    modport master (
        output i_req_valid,
        output i_request,
        output i_mode,
        output i_stall,
        input  o_req_ready,
        input  o_mux_sel,
        input  o_mux_valid,
        input  o_busy,
        input  o_adone,
        input  o_done
    );

    // Scheduler side.
    modport slave (
        input  i_req_valid,
        input  i_request,
        input  i_mode,
        input  i_stall,
        output o_req_ready,
        output o_mux_sel,
        output o_mux_valid,
        output o_busy,
        output o_adone,
        output o_done
    );
endinterface

// File: rtl/fold_scheduler_rr.sv
// Folded-link request scheduler: drains a request vector FOLDS
// channels per cycle, MSB-first or round-robin from a persistent pointer.
module fold_scheduler_rr #(
    parameter int WIDTH = 8,
    parameter int FOLDS = 2
) (
    input logic               i_clk,
    input logic               i_rst,
    fold_scheduler_rr_if.slave bus
);
    localparam int SW = $clog2(WIDTH);
    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    localparam logic [SW-1:0] TOP = SW'(WIDTH - 1);

    logic [0:0]       state_q, state_d;
    logic [WIDTH-1:0] pend_q, pend_d;
    logic             mode_q, mode_d;
    logic [SW-1:0]    ptr_q, ptr_d;
    logic             done_q, done_d;

    logic [SW-1:0]             start_idx;
    logic [WIDTH-1:0][SW-1:0]  ord_idx;
    logic [WIDTH-1:0]          ord_req;
    logic [WIDTH-1:0][CW-1:0]  ord_rank;
    logic [WIDTH-1:0]          ord_gnt;
    logic [CW-1:0]             rank_acc;
    logic [CW-1:0]             req_total;

    logic [FOLDS-1:0][SW-1:0]  lane_sel;
    logic [FOLDS-1:0]          lane_val;
    logic [WIDTH-1:0]          clr_mask;
    logic [SW-1:0]             last_idx;
    logic [SW-1:0]             ptr_dec;

    logic run;
    logic go;
    logic adone;
    logic ready;
    logic accept;
    logic req_nz;

    assign run    = (state_q == S_RUN);
    assign go     = run & ~bus.i_stall;
    assign adone  = go & (req_total <= CW'(FOLDS));
    assign ready  = ~run | adone;
    assign accept = bus.i_req_valid & ready;
    assign req_nz = |bus.i_request;

    // Search order: position j maps to a channel index, counting down
    // from the start point and wrapping modulo WIDTH.
    always_comb begin
        start_idx = mode_q ? ptr_q : TOP;
        for (int j = 0; j < WIDTH; j++) begin
            if (SW'(j) <= start_idx)
                ord_idx[j] = start_idx - SW'(j);
            else
                ord_idx[j] = start_idx - SW'(j) + SW'(WIDTH);
            ord_req[j] = pend_q[ord_idx[j]];
        end
    end

    // Rank each pending bit by how many pending bits precede it;
    // the first FOLDS of them are granted this cycle.
    always_comb begin
        rank_acc = '0;
        for (int j = 0; j < WIDTH; j++) begin
            ord_rank[j] = rank_acc;
            ord_gnt[j]  = ord_req[j] & (rank_acc < CW'(FOLDS));
            rank_acc    = rank_acc + CW'(ord_req[j]);
        end
        req_total = rank_acc;
    end

    // Lane k carries the grant of rank k, so lanes fill without gaps.
    always_comb begin
        lane_sel = '0;
        lane_val = '0;
        for (int k = 0; k < FOLDS; k++) begin
            for (int j = 0; j < WIDTH; j++) begin
                if (ord_gnt[j] && (ord_rank[j] == CW'(k))) begin
                    lane_sel[k] = ord_idx[j];
                    lane_val[k] = 1'b1;
                end
            end
        end
    end

    // Bits to retire and the last channel granted, in search order.
    always_comb begin
        clr_mask = '0;
        last_idx = '0;
        for (int j = 0; j < WIDTH; j++) begin
            if (ord_gnt[j]) begin
                clr_mask[ord_idx[j]] = 1'b1;
                last_idx             = ord_idx[j];
            end
        end
    end

    // Next start point is one below the last grant, wrapping at WIDTH.
    always_comb begin
        if (last_idx == '0)
            ptr_dec = TOP;
        else
            ptr_dec = last_idx - SW'(1);
    end

    // Next-state: consume grants, then load or retire on the drain cycle.
    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        mode_d  = mode_q;
        ptr_d   = ptr_q;
        done_d  = 1'b0;
        if (go) begin
            pend_d = pend_q & ~clr_mask;
            if (mode_q)
                ptr_d = ptr_dec;
        end
        if (adone)
            done_d = 1'b1;
        if (ready) begin
            state_d = S_IDLE;
            if (accept && req_nz) begin
                pend_d  = bus.i_request;
                mode_d  = bus.i_mode;
                state_d = S_RUN;
            end
            if (accept && !req_nz)
                done_d = 1'b1;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= S_IDLE;
            pend_q  <= '0;
            mode_q  <= 1'b0;
            ptr_q   <= TOP;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            mode_q  <= mode_d;
            ptr_q   <= ptr_d;
            done_q  <= done_d;
        end
    end

    assign bus.o_mux_sel   = go ? lane_sel : '0;
    assign bus.o_mux_valid = go ? lane_val : '0;
    assign bus.o_busy      = run;
    assign bus.o_adone     = adone;
    assign bus.o_done      = done_q;
    assign bus.o_req_ready = ready;

endmodule

// File: tb/tb_fold_scheduler_rr.sv
// Bench for fold_scheduler_rr: directed scenarios plus random traffic
// checked against a queue-based scheduling model.
module tb_fold_scheduler_rr;
    localparam int WIDTH = 8;
    localparam int FOLDS = 2;
    localparam int SW    = 3;
    localparam int OW    = FOLDS * SW + FOLDS + 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fold_scheduler_rr_if #(.WIDTH(WIDTH), .FOLDS(FOLDS)) bus ();

    fold_scheduler_rr #(.WIDTH(WIDTH), .FOLDS(FOLDS)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    int total_n = 0;
    int bad_n   = 0;

    logic [OW-1:0] obs;
    logic [OW-1:0] exp_o;
    logic [10:0]   dchk;

    assign obs  = {bus.o_mux_sel, bus.o_mux_valid, bus.o_busy,
                   bus.o_adone, bus.o_done, bus.o_req_ready};
    assign dchk = {bus.o_mux_sel, bus.o_mux_valid, bus.o_adone,
                   bus.o_done, bus.o_busy};

    logic [WIDTH-1:0]         m_pend;
    int                       m_ptr;
    bit                       m_mode, m_run, m_done;
    logic [FOLDS-1:0][SW-1:0] e_sel;
    logic [FOLDS-1:0]         e_val;
    logic [WIDTH-1:0]         e_clr;
    bit                       e_adone, e_ready;
    int                       e_last;

    task automatic model_reset();
        m_pend = '0;
        m_ptr  = WIDTH - 1;
        m_mode = 1'b0;
        m_run  = 1'b0;
        m_done = 1'b0;
    endtask

    task automatic model_eval();
        int q[$];
        int start;
        e_sel = '0;
        e_val = '0;
        e_clr = '0;
        if (m_run && !bus.i_stall) begin
            start = m_mode ? m_ptr : WIDTH - 1;
            for (int j = 0; j < WIDTH; j++) begin
                int c;
                c = (start - j + WIDTH) % WIDTH;
                if (m_pend[c] && q.size() < FOLDS)
                    q.push_back(c);
            end
            for (int k = 0; k < FOLDS; k++) begin
                if (k < q.size()) begin
                    e_sel[k] = SW'(q[k]);
                    e_val[k] = 1'b1;
                    e_clr[q[k]] = 1'b1;
                end
            end
            if (q.size() > 0)
                e_last = q[q.size()-1];
        end
        e_adone = m_run && !bus.i_stall && ((m_pend & ~e_clr) == '0);
        e_ready = !m_run || e_adone;
        exp_o = {e_sel, e_val, m_run, e_adone, m_done, e_ready};
    endtask

    task automatic model_clock();
        bit acc;
        bit nd;
        if (rst) begin
            model_reset();
            return;
        end
        nd  = 1'b0;
        acc = bus.i_req_valid && e_ready;
        if (m_run && !bus.i_stall) begin
            m_pend = m_pend & ~e_clr;
            if (m_mode)
                m_ptr = (e_last + WIDTH - 1) % WIDTH;
        end
        if (e_adone)
            nd = 1'b1;
        if (!m_run || e_adone) begin
            m_run = 1'b0;
            if (acc) begin
                if (bus.i_request != '0) begin
                    m_pend = bus.i_request;
                    m_mode = bus.i_mode;
                    m_run  = 1'b1;
                end else begin
                    nd = 1'b1;
                end
            end
        end
        m_done = nd;
    endtask

    task automatic drive(input bit r, input bit v,
                         input logic [WIDTH-1:0] req,
                         input bit md, input bit st);
        @(negedge clk);
        rst             = r;
        bus.i_req_valid = v;
        bus.i_request   = req;
        bus.i_mode      = md;
        bus.i_stall     = st;
        #1;
        model_eval();
    endtask

    task automatic tick();
        @(posedge clk);
        model_clock();
    endtask

    task automatic test_reset();
        drive(1, 0, 8'h00, 0, 0);
        tick();
        for (int i = 0; i < 2; i++) begin
            drive(1, 1, 8'hFF, 1, 0);
            total_n++;
            if (obs !== {{(OW-1){1'b0}}, 1'b1}) begin
                bad_n++;
                $display("FAIL reset c%0d: got %h want %h", i, obs,
                         {{(OW-1){1'b0}}, 1'b1});
            end
            total_n++;
            if (obs !== exp_o) begin
                bad_n++;
                $display("FAIL reset_model c%0d: got %h want %h", i, obs, exp_o);
            end
            tick();
        end
    endtask

    task automatic test_msb_first();
        logic [11:0] s [5];
        logic [10:0] d [5];
        s = '{{4'b0100, 8'hB5}, {4'b0000, 8'h00}, {4'b0000, 8'h00},
              {4'b0000, 8'h00}, {4'b0000, 8'h00}};
        d = '{{6'b000_000, 2'b00, 3'b000}, {6'b101_111, 2'b11, 3'b001},
              {6'b010_100, 2'b11, 3'b001}, {6'b000_000, 2'b01, 3'b101},
              {6'b000_000, 2'b00, 3'b010}};
        for (int i = 0; i < 5; i++) begin
            drive(s[i][11], s[i][10], s[i][7:0], s[i][9], s[i][8]);
            total_n++;
            if (obs !== exp_o) begin
                bad_n++;
                $display("FAIL msb_model c%0d: got %h want %h", i, obs, exp_o);
            end
            total_n++;
            if (dchk !== d[i]) begin
                bad_n++;
                $display("FAIL msb c%0d: got %h want %h", i, dchk, d[i]);
            end
            tick();
        end
    endtask

    task automatic test_rr_pointer();
        logic [11:0] s [9];
        logic [10:0] d [9];
        s = '{{4'b1000, 8'h00}, {4'b0110, 8'h06}, {4'b0000, 8'h00},
              {4'b0110, 8'h86}, {4'b0000, 8'h00}, {4'b0000, 8'h00},
              {4'b0110, 8'h03}, {4'b0000, 8'h00}, {4'b0000, 8'h00}};
        d = '{{6'b000_000, 2'b00, 3'b000}, {6'b000_000, 2'b00, 3'b000},
              {6'b001_010, 2'b11, 3'b101}, {6'b000_000, 2'b00, 3'b010},
              {6'b010_111, 2'b11, 3'b001}, {6'b000_001, 2'b01, 3'b101},
              {6'b000_000, 2'b00, 3'b010}, {6'b001_000, 2'b11, 3'b101},
              {6'b000_000, 2'b00, 3'b010}};
        for (int i = 0; i < 9; i++) begin
            drive(s[i][11], s[i][10], s[i][7:0], s[i][9], s[i][8]);
            total_n++;
            if (obs !== exp_o) begin
                bad_n++;
                $display("FAIL rr_model c%0d: got %h want %h", i, obs, exp_o);
            end
            total_n++;
            if (dchk !== d[i]) begin
                bad_n++;
                $display("FAIL rr c%0d: got %h want %h", i, dchk, d[i]);
            end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        logic [11:0] s [4];
        logic [10:0] d [4];
        s = '{{4'b0100, 8'hC0}, {4'b0100, 8'h03}, {4'b0000, 8'h00},
              {4'b0000, 8'h00}};
        d = '{{6'b000_000, 2'b00, 3'b000}, {6'b110_111, 2'b11, 3'b101},
              {6'b000_001, 2'b11, 3'b111}, {6'b000_000, 2'b00, 3'b010}};
        for (int i = 0; i < 4; i++) begin
            drive(s[i][11], s[i][10], s[i][7:0], s[i][9], s[i][8]);
            total_n++;
            if (obs !== exp_o) begin
                bad_n++;
                $display("FAIL b2b_model c%0d: got %h want %h", i, obs, exp_o);
            end
            total_n++;
            if (dchk !== d[i]) begin
                bad_n++;
                $display("FAIL b2b c%0d: got %h want %h", i, dchk, d[i]);
            end
            tick();
        end
    endtask

    task automatic test_stall();
        logic [11:0] s [7];
        logic [10:0] d [7];
        s = '{{4'b0100, 8'hF0}, {4'b0101, 8'h0F}, {4'b0001, 8'h00},
              {4'b0101, 8'hFF}, {4'b0000, 8'h00}, {4'b0000, 8'h00},
              {4'b0000, 8'h00}};
        d = '{{6'b000_000, 2'b00, 3'b000}, {6'b000_000, 2'b00, 3'b001},
              {6'b000_000, 2'b00, 3'b001}, {6'b000_000, 2'b00, 3'b001},
              {6'b110_111, 2'b11, 3'b001}, {6'b100_101, 2'b11, 3'b101},
              {6'b000_000, 2'b00, 3'b010}};
        for (int i = 0; i < 7; i++) begin
            drive(s[i][11], s[i][10], s[i][7:0], s[i][9], s[i][8]);
            total_n++;
            if (obs !== exp_o) begin
                bad_n++;
                $display("FAIL stall_model c%0d: got %h want %h", i, obs, exp_o);
            end
            total_n++;
            if (dchk !== d[i]) begin
                bad_n++;
                $display("FAIL stall c%0d: got %h want %h", i, dchk, d[i]);
            end
            if (i >= 1 && i <= 3) begin
                total_n++;
                if (bus.o_req_ready !== 1'b0) begin
                    bad_n++;
                    $display("FAIL stall_ready c%0d: got %b want 0", i,
                             bus.o_req_ready);
                end
            end
            tick();
        end
    endtask

    task automatic test_zero_vector();
        logic [11:0] s [3];
        logic [10:0] d [3];
        s = '{{4'b0100, 8'h00}, {4'b0001, 8'h00}, {4'b0000, 8'h00}};
        d = '{{6'b000_000, 2'b00, 3'b000}, {6'b000_000, 2'b00, 3'b010},
              {6'b000_000, 2'b00, 3'b000}};
        for (int i = 0; i < 3; i++) begin
            drive(s[i][11], s[i][10], s[i][7:0], s[i][9], s[i][8]);
            total_n++;
            if (obs !== exp_o) begin
                bad_n++;
                $display("FAIL zero_model c%0d: got %h want %h", i, obs, exp_o);
            end
            total_n++;
            if (dchk !== d[i]) begin
                bad_n++;
                $display("FAIL zero c%0d: got %h want %h", i, dchk, d[i]);
            end
            tick();
        end
    endtask

    task automatic test_reset_mid_run();
        logic [11:0] s [6];
        logic [10:0] d [6];
        s = '{{4'b0100, 8'hB5}, {4'b0000, 8'h00}, {4'b1000, 8'h00},
              {4'b0110, 8'h81}, {4'b0000, 8'h00}, {4'b0000, 8'h00}};
        d = '{{6'b000_000, 2'b00, 3'b000}, {6'b101_111, 2'b11, 3'b001},
              {6'b010_100, 2'b11, 3'b001}, {6'b000_000, 2'b00, 3'b000},
              {6'b000_111, 2'b11, 3'b101}, {6'b000_000, 2'b00, 3'b010}};
        for (int i = 0; i < 6; i++) begin
            drive(s[i][11], s[i][10], s[i][7:0], s[i][9], s[i][8]);
            total_n++;
            if (obs !== exp_o) begin
                bad_n++;
                $display("FAIL rstrun_model c%0d: got %h want %h", i, obs, exp_o);
            end
            total_n++;
            if (dchk !== d[i]) begin
                bad_n++;
                $display("FAIL rstrun c%0d: got %h want %h", i, dchk, d[i]);
            end
            if (i == 3) begin
                total_n++;
                if (bus.o_req_ready !== 1'b1) begin
                    bad_n++;
                    $display("FAIL rstrun_ready: got %b want 1", bus.o_req_ready);
                end
            end
            tick();
        end
    endtask

    task automatic test_random();
        bit r, v, md, st;
        logic [WIDTH-1:0] rq;
        for (int i = 0; i < 600; i++) begin
            r  = ($urandom_range(63) == 0);
            v  = 1'($urandom_range(1));
            md = 1'($urandom_range(1));
            st = ($urandom_range(3) == 0);
            rq = ($urandom_range(7) == 0) ? '0 : WIDTH'($urandom);
            drive(r, v, rq, md, st);
            total_n++;
            if (obs !== exp_o) begin
                bad_n++;
                $display("FAIL random c%0d: got %h want %h", i, obs, exp_o);
            end
            tick();
        end
    endtask

    initial begin
        rst             = 1'b1;
        bus.i_req_valid = 1'b0;
        bus.i_request   = '0;
        bus.i_mode      = 1'b0;
        bus.i_stall     = 1'b0;
        e_last          = 0;
        model_reset();
        test_reset();
        test_msb_first();
        test_rr_pointer();
        test_back_to_back();
        test_stall();
        test_zero_vector();
        test_reset_mid_run();
        test_random();
        $display("test done: total=%0d bad=%0d", total_n, bad_n);
        $finish;
    end
endmodule

// File: doc/fold_scheduler_rr.md
Name: fold_scheduler_rr

Overview:
Multi-lane request scheduler for NoC link folding. It accepts a WIDTH-bit request vector through a valid/ready handshake. It then issues up to FOLDS channel grants per cycle as mux-select codes until the vector is drained. Two issue orders are supported: fixed MSB-first priority, or round-robin with a start pointer that persists across vectors. It sits between the partition request generator and the folded link muxes.

Parameters:
WIDTH, 8, number of request channels (>= 2).
FOLDS, 2, grant lanes per cycle (1..WIDTH).
SW, $clog2(WIDTH), select code width (derived, not overridden).

Ports:
i_clk  input  1  clock; all state updates on rising edge.
i_rst  input  1  synchronous, active-high reset.
i_req_valid  input  1  request vector valid.
o_req_ready  output  1  block can accept a vector this cycle.
i_request  input  WIDTH  request vector; bit n = channel n wants a slot.
i_mode  input  1  0 = MSB-first, 1 = round-robin; sampled at acceptance.
i_stall  input  1  downstream hold; no grants consumed this cycle.
o_mux_sel  output  FOLDS x SW  per-lane granted channel index.
o_mux_valid  output  FOLDS  per-lane grant valid.
o_busy  output  1  vector pending (state RUN).
o_adone  output  1  current grant cycle drains the vector.
o_done  output  1  one-cycle pulse the cycle after the drain.

Behaviour:
- Reset (synchronous, i_rst high at edge):
  - state=IDLE, pending=0, mode_q=0, ptr=WIDTH-1.
  - o_done=0, o_mux_valid=0, o_mux_sel=0, o_busy=0, o_adone=0, o_req_ready=1.
  - Reset mid-RUN discards the pending vector with no o_done pulse.
- State IDLE:
  - o_req_ready=1.
  - Accept (i_req_valid & o_req_ready) with nonzero i_request: pending<=i_request, mode_q<=i_mode, go RUN.
  - Accept with zero request: stay IDLE, pulse o_done next cycle.
- State RUN:
  - o_busy=1. Grants are combinational from pending/ptr/mode_q, so first grants appear the cycle after acceptance (latency 1).
  - Search order: mode_q=0 scans WIDTH-1 down to 0; mode_q=1 scans ptr, ptr-1, ..., 0, WIDTH-1, ..., ptr+1 (wrap).
  - Lane k gets the (k+1)-th set pending bit in search order. Lanes fill from lane 0 with no gaps.
  - Unused lanes: o_mux_valid=0, o_mux_sel=0.
- Non-stalled RUN cycle:
  - Granted bits are cleared from pending.
  - If mode_q=1: ptr <= (last valid granted index - 1) mod WIDTH.
  - If mode_q=0: ptr holds.
- o_adone=1 in a non-stalled RUN cycle whose grants clear all remaining pending bits.
- Drain cycle (o_adone=1):
  - o_req_ready=1 (back-to-back acceptance, no bubble).
  - If a vector is accepted: load it, stay RUN.
  - Otherwise: go IDLE.
  - Either way, o_done pulses in the following cycle.
- i_stall=1 in RUN:
  - o_mux_valid all 0, o_adone=0, o_req_ready=0.
  - pending and ptr hold.
- o_req_ready is 0 in every RUN cycle except the drain cycle.
- i_request while not ready: ignored, no side effects.
- i_stall in IDLE: no effect.
- WIDTH not a power of 2: indices >= WIDTH never generated; ptr wrap is modulo WIDTH, not 2^SW.
- Width rules:
  - SW-bit arithmetic, with explicit compare-and-wrap for ptr.
  - ptr-1 at ptr=0 yields WIDTH-1.

Test Plan:
1. WIDTH=8, FOLDS=2, mode 0; accept 8'b1011_0101.
   -> cycle+1: sel {7,5}; cycle+2: {4,2}; cycle+3: {0,-}, valid 2'b01, o_adone=1; cycle+4: o_done pulse, IDLE, ptr stays 7.
2. From reset, mode 1, 8'b0000_0110 -> grants {2,1} with o_adone in that cycle; ptr becomes 0.
   Then mode 1, 8'b1000_0110 -> grants {7,2}, then {1}; ptr 0.
3. Mode 0, 8'b1100_0000; in the o_adone cycle present 8'b0000_0011 with i_req_valid.
   -> accepted same edge; next cycle sel {1,0}; o_done pulses in that same cycle for the first vector.
4. Mode 0, 8'b1111_0000 with i_stall high for 3 cycles after acceptance.
   -> o_mux_valid=0 for 3 cycles, then {7,6}, then {5,4} with o_adone; total 5 RUN cycles.
5. Accept zero vector in IDLE -> no RUN cycle, o_done pulse next cycle, o_busy stays 0.
6. Assert i_rst in the second RUN cycle of scenario 1.
   -> next cycle all outputs at reset values, o_req_ready=1, no o_done; a new vector schedules normally from ptr=7.
